// File: rtl/strategy_order_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : strategy_order_manager_if
// Description : Strategy request, gateway order and fill report signals of
//               the strategy order manager, with status feedback.
// Revision    : 1.0 - initial release
// ============================================================================
interface strategy_order_manager_if;
    // Strategy request side
    logic               strategy_signal;
    logic [31:0]        strategy_qty;
    logic               strategy_side;
    logic [31:0]        best_bid;
    logic [31:0]        best_ask;
    // Gateway order handshake
    logic               order_valid;
    logic               order_ready;
    logic [7:0]         order_id;
    logic               order_side;
    logic [31:0]        order_qty;
    logic [31:0]        order_price;
    // Fill reports
    logic               fill_valid;
    logic [7:0]         fill_id;
    logic [31:0]        fill_qty;
    // Status
    logic signed [31:0] current_position;
    logic               busy;
    logic [15:0]        reject_count;
    logic [15:0]        timeout_count;

    // Environment side: strategy, gateway and fill source
    modport master (
        output strategy_signal, strategy_qty, strategy_side, best_bid, best_ask,
        output order_ready, fill_valid, fill_id, fill_qty,
        input  order_valid, order_id, order_side, order_qty, order_price,
        input  current_position, busy, reject_count, timeout_count
    );

    // Order manager side
    modport slave (
        input  strategy_signal, strategy_qty, strategy_side, best_bid, best_ask,
        input  order_ready, fill_valid, fill_id, fill_qty,
        output order_valid, order_id, order_side, order_qty, order_price,
        output current_position, busy, reject_count, timeout_count
    );
endinterface
`default_nettype wire

// File: rtl/strategy_order_manager.sv
`default_nettype none
// ============================================================================
// Module      : strategy_order_manager
// Description : Queues strategy requests, applies a position-limit risk
//               check, issues one order at a time over valid/ready and
//               tracks fills into a signed net position.
// Revision    : 1.0 - initial release
// ============================================================================
module strategy_order_manager #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_POSITION   = 1000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    strategy_order_manager_if.slave bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic signed [33:0] c_MAX_POS  = 34'(MAX_POSITION);
    localparam logic signed [33:0] c_MIN_POS  = -c_MAX_POS;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_SEND       = 2'd1;
    localparam logic [1:0] c_AWAIT_FILL = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    logic [64:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]    r_wr_ptr;
    logic [c_PTR_W:0]    r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [64:0]         w_head;
    logic                w_head_side;
    logic [31:0]         w_head_qty;
    logic [31:0]         w_head_price;

    logic signed [33:0]  w_pos_ext;
    logic signed [33:0]  w_qty_ext;
    logic signed [33:0]  w_buy_sum;
    logic signed [33:0]  w_sell_dif;
    logic                w_risk_ok;

    logic                w_pop;
    logic                w_pass;
    logic                w_reject;
    logic                w_xfer;
    logic                w_fill_acc;
    logic [31:0]         w_applied;
    logic                w_done;
    logic                w_timeout;

    logic                r_order_valid;
    logic [7:0]          r_order_id;
    logic                r_order_side;
    logic [31:0]         r_order_qty;
    logic [31:0]         r_order_price;
    logic [31:0]         r_remaining;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic signed [31:0]  r_position;
    logic [15:0]         r_reject_count;
    logic [15:0]         r_timeout_count;

    // ------------------------------------------------------------------
    // Request queue status and head decode
    // ------------------------------------------------------------------
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                          (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    // A full queue still takes a push when the head leaves in the same cycle
    assign w_push       = bus.strategy_signal && (!w_full || w_pop);
    assign w_drop       = bus.strategy_signal && w_full && !w_pop;
    assign w_head       = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_side  = w_head[64];
    assign w_head_qty   = w_head[63:32];
    assign w_head_price = w_head[31:0];

    // Risk check in 34-bit signed so a huge quantity can never wrap past the limit
    assign w_pos_ext  = {{2{r_position[31]}}, r_position};
    assign w_qty_ext  = {2'b00, w_head_qty};
    assign w_buy_sum  = w_pos_ext + w_qty_ext;
    assign w_sell_dif = w_pos_ext - w_qty_ext;
    assign w_risk_ok  = (w_head_qty != 32'd0) &&
                        (w_head_side ? (w_buy_sum <= c_MAX_POS) : (w_sell_dif >= c_MIN_POS));

    assign w_applied  = (bus.fill_qty < r_remaining) ? bus.fill_qty : r_remaining;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:       if (w_pass)              w_next_state = c_SEND;
            c_SEND:       if (w_xfer)              w_next_state = c_AWAIT_FILL;
            c_AWAIT_FILL: if (w_done || w_timeout) w_next_state = c_IDLE;
            default:                               w_next_state = c_IDLE;
        endcase
    end

    // State-qualified control strobes
    always_comb begin
        w_pop      = (r_state == c_IDLE) && !w_empty;
        w_pass     = w_pop && w_risk_ok;
        w_reject   = w_pop && !w_risk_ok;
        w_xfer     = (r_state == c_SEND) && r_order_valid && bus.order_ready;
        w_fill_acc = (r_state == c_AWAIT_FILL) && bus.fill_valid && (bus.fill_id == r_order_id);
        w_done     = w_fill_acc && (w_applied == r_remaining);
        // An accepted fill in the expiry cycle takes precedence over the timeout
        w_timeout  = (r_state == c_AWAIT_FILL) && !w_fill_acc && (r_tmo_cnt == c_TMO_LAST);
    end

    // Queue pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Queue storage; the limit price is chosen from the book in the push cycle
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {bus.strategy_side, bus.strategy_qty,
                                             bus.strategy_side ? bus.best_ask : bus.best_bid};
        end
    end

    // Order registers: loaded on a passing pop, valid held until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order_valid <= 1'b0;
            r_order_side  <= 1'b0;
            r_order_qty   <= '0;
            r_order_price <= '0;
        end else if (w_pass) begin
            r_order_valid <= 1'b1;
            r_order_side  <= w_head_side;
            r_order_qty   <= w_head_qty;
            r_order_price <= w_head_price;
        end else if (w_xfer) begin
            r_order_valid <= 1'b0;
        end
    end

    // Remaining quantity and net position track accepted fills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_position  <= '0;
        end else if (w_pass) begin
            r_remaining <= w_head_qty;
        end else if (w_fill_acc) begin
            r_remaining <= r_remaining - w_applied;
            r_position  <= r_order_side ? (r_position + $signed(w_applied))
                                        : (r_position - $signed(w_applied));
        end
    end

    // Fill-inactivity counter, restarted by the handshake and by each accepted fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_xfer || w_fill_acc || w_timeout) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_AWAIT_FILL) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
        end
    end

    // Order id advances when an order completes or is abandoned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order_id <= '0;
        end else if (w_done || w_timeout) begin
            r_order_id <= r_order_id + 8'd1;
        end
    end

    // Saturating reject and timeout statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject_count  <= '0;
            r_timeout_count <= '0;
        end else begin
            if ((w_reject || w_drop) && (r_reject_count != 16'hFFFF)) begin
                r_reject_count <= r_reject_count + 16'd1;
            end
            if (w_timeout && (r_timeout_count != 16'hFFFF)) begin
                r_timeout_count <= r_timeout_count + 16'd1;
            end
        end
    end

    assign bus.order_valid      = r_order_valid;
    assign bus.order_id         = r_order_id;
    assign bus.order_side       = r_order_side;
    assign bus.order_qty        = r_order_qty;
    assign bus.order_price      = r_order_price;
    assign bus.current_position = r_position;
    assign bus.busy             = (r_state != c_IDLE);
    assign bus.reject_count     = r_reject_count;
    assign bus.timeout_count    = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_strategy_order_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_strategy_order_manager
// Description : Self-checking bench for strategy_order_manager: scoreboard
//               of expected orders, risk-limit vector table and hand-written
//               multi-cycle sequences (backpressure, queue, timeout, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strategy_order_manager;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_POS    = 1000;
    localparam int TMO        = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strategy_order_manager_if bus ();

    strategy_order_manager #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .MAX_POSITION   (MAX_POS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  id;
        logic        side;
        logic [31:0] qty;
        logic [31:0] price;
    } ord_t;

    typedef struct {
        logic        side;
        logic [31:0] qty;
        logic [31:0] fill;
        bit          pass;
        int          pos_after;
    } risk_vec_t;

    ord_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          model_pos = 0;
    int          model_rej = 0;
    int          model_tmo = 0;
    logic [7:0]  next_exp_id = 8'd0;
    bit          model_await = 1'b0;
    logic [7:0]  cur_id = 8'd0;
    logic        cur_side = 1'b0;
    logic [31:0] cur_rem = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_pos(input string nm);
        chk(nm, {32'b0, bus.current_position}, {32'b0, model_pos});
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pos   = 0;
        model_rej   = 0;
        model_tmo   = 0;
        next_exp_id = 8'd0;
        model_await = 1'b0;
    endtask

    // One-cycle request; book prices are scrambled afterwards so a late sample would show
    task automatic push_req(input logic side, input logic [31:0] q,
                            input logic [31:0] bid, input logic [31:0] ask, input bit expect_order);
        ord_t e;
        bus.strategy_signal = 1'b1;
        bus.strategy_side   = side;
        bus.strategy_qty    = q;
        bus.best_bid        = bid;
        bus.best_ask        = ask;
        if (expect_order) begin
            e.id    = next_exp_id;
            e.side  = side;
            e.qty   = q;
            e.price = side ? ask : bid;
            exp_q.push_back(e);
            next_exp_id = next_exp_id + 8'd1;
        end
        @(negedge clk);
        bus.strategy_signal = 1'b0;
        bus.best_bid        = $urandom;
        bus.best_ask        = $urandom;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.order_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.order_valid) begin
            n_chk++;
            $display("FAIL order_valid wait: got 0 expected 1 within 20 cycles at %0t", $time);
        end
    endtask

    // Compare offered order with scoreboard head, hold backpressure, then handshake
    task automatic send_order(input int delay, input bit probe_fill);
        ord_t e;
        wait_valid();
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard: got order with no expected entry at %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        chk("order_id",    {56'b0, bus.order_id},    {56'b0, e.id});
        chk("order_side",  {63'b0, bus.order_side},  {63'b0, e.side});
        chk("order_qty",   {32'b0, bus.order_qty},   {32'b0, e.qty});
        chk("order_price", {32'b0, bus.order_price}, {32'b0, e.price});
        for (int i = 0; i < delay; i++) begin
            if (probe_fill && i == 0) begin
                bus.fill_valid = 1'b1;
                bus.fill_id    = e.id;
                bus.fill_qty   = 32'd50;
            end
            @(negedge clk);
            bus.fill_valid = 1'b0;
            chk("valid held", {63'b0, bus.order_valid}, 64'd1);
            chk("qty held",   {32'b0, bus.order_qty},   {32'b0, e.qty});
            chk("price held", {32'b0, bus.order_price}, {32'b0, e.price});
        end
        bus.order_ready = 1'b1;
        @(negedge clk);
        bus.order_ready = 1'b0;
        chk("valid after xfer", {63'b0, bus.order_valid}, 64'd0);
        cur_id      = e.id;
        cur_side    = e.side;
        cur_rem     = e.qty;
        model_await = 1'b1;
    endtask

    task automatic do_fill(input logic [7:0] id, input logic [31:0] q);
        logic [31:0] ap;
        bus.fill_valid = 1'b1;
        bus.fill_id    = id;
        bus.fill_qty   = q;
        @(negedge clk);
        bus.fill_valid = 1'b0;
        if (model_await && id == cur_id) begin
            ap = (q < cur_rem) ? q : cur_rem;
            model_pos = cur_side ? model_pos + int'(ap) : model_pos - int'(ap);
            cur_rem = cur_rem - ap;
            if (cur_rem == 32'd0) model_await = 1'b0;
        end
        chk_pos("position after fill");
        chk("busy after fill", {63'b0, bus.busy}, {63'b0, model_await});
    endtask

    risk_vec_t rv[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rv[0]  = '{1'b1, 32'd950,        32'd950,  1'b1,   950};
        rv[1]  = '{1'b1, 32'd100,        32'd0,    1'b0,   950};
        rv[2]  = '{1'b1, 32'd50,         32'd50,   1'b1,  1000};
        rv[3]  = '{1'b0, 32'd2000,       32'd2000, 1'b1, -1000};
        rv[4]  = '{1'b0, 32'd1,          32'd0,    1'b0, -1000};
        rv[5]  = '{1'b1, 32'd0,          32'd0,    1'b0, -1000};
        rv[6]  = '{1'b1, 32'd1000,       32'd1000, 1'b1,     0};
        rv[7]  = '{1'b0, 32'd1000,       32'd1000, 1'b1, -1000};
        rv[8]  = '{1'b0, 32'd1,          32'd0,    1'b0, -1000};
        rv[9]  = '{1'b1, 32'd1000,       32'd1000, 1'b1,     0};
        rv[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,    1'b0,     0};
        rv[11] = '{1'b0, 32'd0,          32'd0,    1'b0,     0};

        rst = 1'b1;
        bus.strategy_signal = 1'b0;
        bus.strategy_qty    = '0;
        bus.strategy_side   = 1'b0;
        bus.best_bid        = '0;
        bus.best_ask        = '0;
        bus.order_ready     = 1'b0;
        bus.fill_valid      = 1'b0;
        bus.fill_id         = '0;
        bus.fill_qty        = '0;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        chk("rst order_valid", {63'b0, bus.order_valid}, 64'd0);
        chk("rst busy",        {63'b0, bus.busy},        64'd0);
        chk("rst order_id",    {56'b0, bus.order_id},    64'd0);
        chk("rst position",    {32'b0, bus.current_position}, 64'd0);
        chk("rst reject",      {48'b0, bus.reject_count},  64'd0);
        chk("rst timeout",     {48'b0, bus.timeout_count}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- basic round trip ----------------
        push_req(1'b1, 32'd100, 32'd990, 32'd1000, 1'b1);
        chk("latency N+1 valid", {63'b0, bus.order_valid}, 64'd0);
        @(negedge clk);
        chk("latency N+2 valid", {63'b0, bus.order_valid}, 64'd1);
        send_order(3, 1'b0);
        do_fill(cur_id, 32'd100);
        chk("round trip pos", {32'b0, bus.current_position}, 64'd100);
        chk("next id", {56'b0, bus.order_id}, 64'd1);

        // ---------------- partial and over-fill ----------------
        push_req(1'b0, 32'd100, 32'd995, 32'd1005, 1'b1);
        send_order(2, 1'b1);
        chk("fill in SEND ignored", {32'b0, bus.current_position}, 64'd100);
        do_fill(cur_id + 8'd1, 32'd40);
        do_fill(cur_id, 32'd40);
        chk("partial pos", {32'b0, bus.current_position}, 64'd60);
        do_fill(cur_id, 32'd80);
        chk("over-fill pos", {32'b0, bus.current_position}, 64'd0);

        // ---------------- risk-limit vector table ----------------
        for (int i = 0; i < 12; i++) begin
            push_req(rv[i].side, rv[i].qty, 32'd500 + 32'(i), 32'd600 + 32'(i), rv[i].pass);
            if (rv[i].pass) begin
                send_order(0, 1'b0);
                do_fill(cur_id, rv[i].fill);
            end else begin
                model_rej++;
                repeat (3) @(negedge clk);
                chk("reject no valid", {63'b0, bus.order_valid}, 64'd0);
                chk("reject busy",     {63'b0, bus.busy},        64'd0);
            end
            chk("risk reject_count", {48'b0, bus.reject_count}, 64'(model_rej));
            chk("risk pos", {32'b0, bus.current_position}, {32'b0, rv[i].pos_after});
        end

        // ---------------- queue boundaries ----------------
        for (int i = 1; i <= 5; i++) push_req(1'b1, 32'(10 * i), 32'd700, 32'd710 + 32'(i), 1'b1);
        push_req(1'b1, 32'd60, 32'd700, 32'd799, 1'b0);
        model_rej++;
        chk("queue drop reject", {48'b0, bus.reject_count}, 64'(model_rej));
        send_order(0, 1'b0);
        do_fill(cur_id, 32'd10);
        push_req(1'b1, 32'd70, 32'd700, 32'd777, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_order(0, 1'b0);
            do_fill(cur_id, cur_rem);
        end
        chk("queue drained", 64'(exp_q.size()), 64'd0);
        chk("queue pos", {32'b0, bus.current_position}, 64'd220);
        chk("queue reject", {48'b0, bus.reject_count}, 64'(model_rej));

        // ---------------- timeout, then fill exactly on the timeout cycle ----------------
        push_req(1'b1, 32'd10, 32'd800, 32'd810, 1'b1);
        send_order(0, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        chk("pre-timeout busy", {63'b0, bus.busy}, 64'd1);
        @(negedge clk);
        model_await = 1'b0;
        model_tmo++;
        chk("timeout busy",  {63'b0, bus.busy}, 64'd0);
        chk("timeout count", {48'b0, bus.timeout_count}, 64'(model_tmo));
        chk("timeout id",    {56'b0, bus.order_id}, {56'b0, next_exp_id});
        chk_pos("timeout pos");
        push_req(1'b1, 32'd10, 32'd800, 32'd820, 1'b1);
        send_order(0, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        chk("edge busy", {63'b0, bus.busy}, 64'd1);
        do_fill(cur_id, 32'd10);
        chk("fill wins count", {48'b0, bus.timeout_count}, 64'(model_tmo));
        chk("fill wins pos", {32'b0, bus.current_position}, 64'd230);

        // ---------------- id wrap ----------------
        begin
            int n;
            n = (next_exp_id == 8'd0) ? 256 : 256 - int'(next_exp_id);
            for (int i = 0; i < n; i++) begin
                push_req(i[0] ? 1'b0 : 1'b1, 32'd1, 32'd900, 32'd901, 1'b1);
                send_order(0, 1'b0);
                do_fill(cur_id, 32'd1);
            end
        end
        chk("id wrapped", {56'b0, bus.order_id}, 64'd0);
        push_req(1'b0, 32'd5, 32'd333, 32'd444, 1'b1);
        send_order(0, 1'b0);
        do_fill(cur_id, 32'd5);

        // ---------------- reset during SEND ----------------
        push_req(1'b1, 32'd10, 32'd100, 32'd110, 1'b1);
        wait_valid();
        #2 rst = 1'b1;
        #1;
        chk("async rst valid SEND", {63'b0, bus.order_valid}, 64'd0);
        chk("async rst busy SEND",  {63'b0, bus.busy},        64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // ---------------- reset during AWAIT_FILL with queued requests ----------------
        push_req(1'b1, 32'd30, 32'd100, 32'd120, 1'b1);
        send_order(0, 1'b0);
        do_fill(cur_id, 32'd10);
        push_req(1'b1, 32'd11, 32'd100, 32'd121, 1'b0);
        push_req(1'b0, 32'd12, 32'd100, 32'd122, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy AWAIT", {63'b0, bus.busy}, 64'd0);
        chk("async rst pos",        {32'b0, bus.current_position}, 64'd0);
        chk("async rst id",         {56'b0, bus.order_id}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("queue discarded busy",  {63'b0, bus.busy},        64'd0);
        chk("queue discarded valid", {63'b0, bus.order_valid}, 64'd0);
        push_req(1'b0, 32'd7, 32'd4242, 32'd4343, 1'b1);
        send_order(1, 1'b0);
        do_fill(cur_id, 32'd7);
        chk("post-reset pos", {32'b0, bus.current_position}, 64'hFFFF_FFF9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/strategy_order_manager.md
# strategy_order_manager

Downstream consumer of the trading strategy's signal interface. It queues strategy buy/sell requests and applies a position-limit risk check. It issues one order at a time to the exchange gateway over a valid/ready handshake, then tracks fills against that order. It maintains the signed `current_position` that feeds back into the strategy, closing the position loop.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries (power of two, ≥2).
- `MAX_POSITION`, 1000: absolute position limit, in shares.
- `TIMEOUT_CYCLES`, 1024: cycles without a fill before the outstanding order is abandoned.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `strategy_signal`, input, 1: one-cycle request strobe from the strategy.
- `strategy_qty`, input, 32: requested quantity (unsigned).
- `strategy_side`, input, 1: 1 = BUY, 0 = SELL.
- `best_bid`, input, 32: top-of-book bid, used as the SELL limit price.
- `best_ask`, input, 32: top-of-book ask, used as the BUY limit price.
- `order_valid`, output, 1: order offered to the gateway.
- `order_ready`, input, 1: gateway accepts the order.
- `order_id`, output, 8: identifier of the offered or outstanding order.
- `order_side`, output, 1: side of the order.
- `order_qty`, output, 32: quantity of the order.
- `order_price`, output, 32: limit price of the order.
- `fill_valid`, input, 1: fill report strobe.
- `fill_id`, input, 8: order id the fill applies to.
- `fill_qty`, input, 32: filled quantity.
- `current_position`, output, signed 32: net position.
- `busy`, output, 1: high whenever the state is not IDLE.
- `reject_count`, output, 16: risk rejections plus queue-full drops; saturates at 0xFFFF.
- `timeout_count`, output, 16: abandoned orders; saturates at 0xFFFF.

## Operation
Request queue:
- A push occurs when `strategy_signal` is high.
- Each entry stores {side, qty, price}, where price = `best_ask` if BUY, else `best_bid`, sampled in the push cycle.
- Push while full with no pop in the same cycle: request dropped, `reject_count`++.
- Push while full with a pop in the same cycle: push accepted.

State machine (IDLE, SEND, AWAIT_FILL):
- **IDLE:** if the queue is non-empty, pop the head entry and run the risk check against the registered `current_position`.
  - BUY rejected if pos + qty > MAX_POSITION. SELL rejected if pos − qty < −MAX_POSITION.
  - Evaluate in 34-bit signed arithmetic; no wrap.
  - qty = 0 is rejected.
  - On reject: `reject_count`++, stay in IDLE.
  - On pass: latch the entry into the order registers, set remaining = qty, go to SEND.
- **SEND:** `order_valid` = 1, payload held stable.
  - Transfer occurs when `order_valid` & `order_ready` → AWAIT_FILL, timeout counter cleared.
  - Fills are ignored in SEND.
- **AWAIT_FILL:** a fill is accepted when `fill_valid` & `fill_id` == `order_id`; other fills are ignored.
  - applied = min(`fill_qty`, remaining).
  - Position += applied (BUY) or −= applied (SELL). remaining −= applied. Timeout counter cleared.
  - remaining == 0 → IDLE, and `order_id` increments (8-bit wrap, 255 → 0).
  - Timeout counter reaches TIMEOUT_CYCLES with no accepted fill in that cycle → IDLE, `timeout_count`++, `order_id` increments.
  - If an accepted fill and the timeout coincide, the fill wins.

## Timing
- Reset values: all outputs 0, `order_id` 0, queue empty, state IDLE.
- Reset asserted mid-operation: `order_valid` drops asynchronously, queue and outstanding order discarded, position cleared.
- Request-to-order latency:
  - `strategy_signal` in cycle N → entry visible in N+1 → popped in N+1 → `order_valid` high in N+2.
  - Minimum 2 cycles when the queue is empty and the state is IDLE.
- A pass or reject occurs in the pop cycle. At most one pop per cycle, and only in IDLE.
- `current_position` updates on the edge after an accepted fill. The risk check in that same cycle sees the old value.
- `order_valid` is never deasserted before the handshake, except by reset.
- `busy` and `order_*` are registered outputs.

## Test plan
- **Basic round trip:** reset; `best_ask`=1000, BUY 100 → `order_valid` 2 cycles later with price 1000, id 0. Ready after 3 cycles of backpressure (payload stable throughout). Then fill id 0 qty 100 → `current_position`=100, IDLE, next id 1.
- **Partial and over-fill:** SELL 100 from pos 100, fills of 40 then 80 → position 60 then 0, applied 40 and 60. Fill with wrong id ignored; fill during SEND ignored.
- **Risk limits:** pos 950, BUY 100 → rejected, `reject_count`=1, no `order_valid`. SELL 1000 from pos 0 passes; SELL 1 from pos −1000 rejected. qty 0 rejected.
- **Queue boundaries:** hold `order_ready` low; 5 back-to-back requests with FIFO_DEPTH 4 → one in SEND, 4 queued, 6th dropped. Push and pop in the same cycle while full is accepted.
- **Timeout and id wrap:** no fill for TIMEOUT_CYCLES → IDLE, `timeout_count`=1. A fill arriving exactly on the timeout cycle is applied with no timeout. 256 orders → id wraps to 0.
- **Reset mid-order:** assert `rst` during SEND and AWAIT_FILL → outputs 0 asynchronously, queue empty, position 0.
